btn_ctrl_bank: RTL

BTN_CTRL_BANK -- requirements
Module: btn_ctrl_bank

---
 rtl/btn_ctrl_bank.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/btn_ctrl_bank.sv
// btn_ctrl_bank: a bank of independent button channels. Each channel
// synchronises and debounces its raw input, strobes once on every accepted
// press, and drives a control output whose behaviour is chosen by a global
// mode (toggle, momentary, one-shot pulse, hold). A per-channel override
// takes priority over presses and mode.
module btn_ctrl_bank #(
  parameter int N_CH       = 4,
  parameter int DEB_CYCLES = 16,
  parameter int PULSE_LEN  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  input  logic [N_CH-1:0] sw_force,
  input  logic [N_CH-1:0] sw_val,
  input  logic [1:0]      mode,
  output logic [N_CH-1:0] upr,
  output logic [N_CH-1:0] press_stb
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int PW = $clog2(PULSE_LEN + 1);

  localparam logic [DW-1:0] DEB_MAX    = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_LEN);
  localparam logic [DW-1:0] DEB_ONE    = DW'(1);
  localparam logic [PW-1:0] PULSE_ONE  = PW'(1);
  localparam logic [PW-1:0] PULSE_ZERO = PW'(0);

  localparam logic [1:0] MODE_TOGGLE  = 2'b00;
  localparam logic [1:0] MODE_MOMENT  = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;          // btn_s: synchronised button level
  logic [N_CH-1:0] deb_q,   deb_d;
  logic [N_CH-1:0] upr_q,   upr_d;
  logic [N_CH-1:0] press_q, press_d;
  logic [1:0]      mode_q;
  logic [DW-1:0]   deb_cnt_q   [N_CH];
  logic [DW-1:0]   deb_cnt_d   [N_CH];
  logic [PW-1:0]   pulse_cnt_q [N_CH];
  logic [PW-1:0]   pulse_cnt_d [N_CH];
  logic            mode_chg_s;

  // Next-state for debounce, press detection, one-shot counters and outputs.
  always_comb begin
    deb_d       = deb_q;
    press_d     = '0;
    upr_d       = upr_q;
    deb_cnt_d   = deb_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    mode_chg_s  = (mode != mode_q);

    for (int i = 0; i < N_CH; i++) begin
      // Debounce: any agreement restarts the count, so glitches never accumulate.
      if (sync2_q[i] == deb_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_MAX) begin
        deb_d[i]     = sync2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DEB_ONE;
      end

      press_d[i] = deb_d[i] & ~deb_q[i];

      // A mode switch abandons any running pulse; upr keeps its value.
      if (mode_chg_s) begin
        pulse_cnt_d[i] = PULSE_ZERO;
      end else begin
        pulse_cnt_d[i] = pulse_cnt_q[i];
      end

      if (sw_force[i]) begin
        // Override wins over presses and mode; no pulse survives it.
        upr_d[i]       = sw_val[i];
        pulse_cnt_d[i] = PULSE_ZERO;
      end else begin
        case (mode)
          MODE_TOGGLE: begin
            if (press_d[i]) begin
              upr_d[i] = ~upr_q[i];
            end else begin
              upr_d[i] = upr_q[i];
            end
          end
          MODE_MOMENT: begin
            upr_d[i] = deb_d[i];
          end
          MODE_ONESHOT: begin
            if (press_d[i]) begin
              upr_d[i]       = 1'b1;
              pulse_cnt_d[i] = PULSE_LOAD;
            end else if (!mode_chg_s && (pulse_cnt_q[i] != PULSE_ZERO)) begin
              pulse_cnt_d[i] = pulse_cnt_q[i] - PULSE_ONE;
              if (pulse_cnt_q[i] == PULSE_ONE) begin
                upr_d[i] = 1'b0;
              end else begin
                upr_d[i] = upr_q[i];
              end
            end else begin
              upr_d[i] = upr_q[i];
            end
          end
          MODE_HOLD: begin
            upr_d[i] = upr_q[i];
          end
          default: begin
            upr_d[i] = upr_q[i];
          end
        endcase
      end
    end
  end

  // State registers with synchronous reset clearing every flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      upr_q       <= '0;
      press_q     <= '0;
      mode_q      <= 2'b00;
      deb_cnt_q   <= '{default: '0};
      pulse_cnt_q <= '{default: '0};
    end else begin
      sync1_q     <= btn;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      upr_q       <= upr_d;
      press_q     <= press_d;
      mode_q      <= mode;
      deb_cnt_q   <= deb_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign upr       = upr_q;
  assign press_stb = press_q;

endmodule
